neuron_cfg_loader: RTL and testbench

Streaming configuration transmitter that feeds neuron weight memories. It accepts framed 32-bit words from the host-side stream and emits the `weightValid`/`biasValid`/`config_layer_num`/`config_neuron_num` broadcast that every neuron in the fully connected network decodes. It sits between the host DMA/stream bridge and the layer array, with one instance driving all layers.

---
 rtl/nn_cfg_pkg.sv | 20 ++
 rtl/neuron_cfg_loader.sv | 116 +++++++++++
 tb/tb_neuron_cfg_loader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_cfg_pkg.sv
// Shared types and constants for the neuron configuration loader.
// The header word packs the target layer above the target neuron.
package nn_cfg_pkg;

   typedef enum logic [1:0] {
      HDR,
      LEN,
      WGT,
      BIAS
   } state_t;

   localparam int HDR_LAYER_MSB  = 31;
   localparam int HDR_LAYER_LSB  = 16;
   localparam int HDR_NEURON_MSB = 15;
   localparam int HDR_NEURON_LSB = 0;

   // No neuron decodes this id, so an idle bus addresses nobody.
   localparam logic [31:0] CFG_IDLE_ID = 32'hFFFF_FFFF;

endpackage

// File: rtl/neuron_cfg_loader.sv
// Frames host words into weight/bias broadcasts for the neuron array.
// Define CFG_BIAS_EN to carry a trailing bias word in every frame.
module neuron_cfg_loader
   import nn_cfg_pkg::*;
#(
   parameter int maxWeight = 784,
   parameter int cntWidth  = $clog2(maxWeight + 1)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        weightValid,
   output logic [31:0] weightValue,
   output logic        biasValid,
   output logic [31:0] biasValue,
   output logic [31:0] config_layer_num,
   output logic [31:0] config_neuron_num,
   output logic        busy,
   output logic        frame_done,
   output logic        err,
   output logic [15:0] frames_loaded
);

   state_t              state;
   logic [cntWidth-1:0] remaining;
   logic                accept;
   logic                bad_len;
   logic                last_wgt;

   assign s_ready  = !rst;
   assign accept   = s_valid & s_ready;
   assign bad_len  = (s_data == 32'd0) || (s_data > 32'(maxWeight));
   assign last_wgt = (remaining == cntWidth'(1));

`ifndef CFG_BIAS_EN
   assign biasValid = 1'b0;
   assign biasValue = 32'd0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state             <= HDR;
         remaining         <= '0;
         weightValid       <= 1'b0;
         weightValue       <= 32'd0;
         frame_done        <= 1'b0;
         err               <= 1'b0;
         busy              <= 1'b0;
         frames_loaded     <= 16'd0;
         config_layer_num  <= CFG_IDLE_ID;
         config_neuron_num <= CFG_IDLE_ID;
`ifdef CFG_BIAS_EN
         biasValid         <= 1'b0;
         biasValue         <= 32'd0;
`endif
      end else begin
         weightValid <= 1'b0;
         frame_done  <= 1'b0;
         err         <= 1'b0;
`ifdef CFG_BIAS_EN
         biasValid   <= 1'b0;
`endif
         if (accept) begin
            unique case (state)
               HDR: begin
                  config_layer_num <=
                     {16'h0, s_data[HDR_LAYER_MSB:HDR_LAYER_LSB]};
                  config_neuron_num <=
                     {16'h0, s_data[HDR_NEURON_MSB:HDR_NEURON_LSB]};
                  busy  <= 1'b1;
                  state <= LEN;
               end
               LEN: begin
                  if (bad_len) begin
                     err   <= 1'b1;
                     busy  <= 1'b0;
                     state <= HDR;
                  end else begin
                     remaining <= s_data[cntWidth-1:0];
                     state     <= WGT;
                  end
               end
               WGT: begin
                  weightValid <= 1'b1;
                  weightValue <= s_data;
                  remaining   <= remaining - cntWidth'(1);
                  if (last_wgt) begin
`ifdef CFG_BIAS_EN
                     state <= BIAS;
`else
                     state         <= HDR;
                     busy          <= 1'b0;
                     frame_done    <= 1'b1;
                     frames_loaded <= frames_loaded + 16'd1;
`endif
                  end
               end
`ifdef CFG_BIAS_EN
               BIAS: begin
                  biasValid     <= 1'b1;
                  biasValue     <= s_data;
                  state         <= HDR;
                  busy          <= 1'b0;
                  frame_done    <= 1'b1;
                  frames_loaded <= frames_loaded + 16'd1;
               end
`endif
               default: state <= HDR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_neuron_cfg_loader.sv
// Scoreboard bench for neuron_cfg_loader; a frame-level model pushes
// expected broadcast events, a negedge monitor pops and compares them.
module tb_neuron_cfg_loader;

   localparam int MAXW = 784;
`ifdef CFG_BIAS_EN
   localparam bit BIAS_EN = 1'b1;
`else
   localparam bit BIAS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] s_data = 32'd0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic        weightValid;
   logic [31:0] weightValue;
   logic        biasValid;
   logic [31:0] biasValue;
   logic [31:0] config_layer_num;
   logic [31:0] config_neuron_num;
   logic        busy;
   logic        frame_done;
   logic        err;
   logic [15:0] frames_loaded;

   neuron_cfg_loader #(.maxWeight(MAXW)) dut (
      .clk(clk),
      .rst(rst),
      .s_data(s_data),
      .s_valid(s_valid),
      .s_ready(s_ready),
      .weightValid(weightValid),
      .weightValue(weightValue),
      .biasValid(biasValid),
      .biasValue(biasValue),
      .config_layer_num(config_layer_num),
      .config_neuron_num(config_neuron_num),
      .busy(busy),
      .frame_done(frame_done),
      .err(err),
      .frames_loaded(frames_loaded)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum logic [2:0] {EV_HDR, EV_W, EV_B, EV_DONE, EV_ERR} ev_kind_t;

   typedef struct packed {
      logic [2:0]  kind;
      logic [31:0] data;
      logic [31:0] layer;
      logic [31:0] neuron;
      logic [15:0] frames;
      logic        bz;
      logic [31:0] cyc;
   } ev_t;

   ev_t         exp_q[$];
   int          compared = 0;
   int          mismatched = 0;
   int          wcount = 0;
   logic [15:0] m_frames = 16'd0;
   logic        busy_q = 1'b0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
      compared++;
      if (act !== want) begin
         mismatched++;
         $display("FAIL %s actual=%h required=%h", nm, act, want);
      end
   endtask

   task automatic score(ev_t a);
      ev_t e;
      compared++;
      if (exp_q.size() == 0) begin
         mismatched++;
         $display("FAIL unexpected_event kind=%0d data=%h cyc=%0d",
                  a.kind, a.data, a.cyc);
         return;
      end
      e = exp_q.pop_front();
      if (a !== e) begin
         mismatched++;
         $display("FAIL event actual kind=%0d data=%h L=%h N=%h fr=%0d bz=%0d cyc=%0d required kind=%0d data=%h L=%h N=%h fr=%0d bz=%0d cyc=%0d",
                  a.kind, a.data, a.layer, a.neuron, a.frames, a.bz, a.cyc,
                  e.kind, e.data, e.layer, e.neuron, e.frames, e.bz, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      ev_t a;
      if (!rst) begin
         a        = '0;
         a.layer  = config_layer_num;
         a.neuron = config_neuron_num;
         a.frames = frames_loaded;
         a.bz     = busy;
         a.cyc    = cyc;
         if (busy && !busy_q) begin
            a.kind = EV_HDR;
            score(a);
         end
         if (weightValid) begin
            chk("wv_bv_exclusive", {31'd0, biasValid}, 32'd0);
            a.kind = EV_W;
            a.data = weightValue;
            score(a);
            wcount++;
         end
         if (biasValid) begin
            a.kind = EV_B;
            a.data = biasValue;
            score(a);
         end
         if (frame_done) begin
            a.kind = EV_DONE;
            a.data = 32'd0;
            score(a);
         end
         if (err) begin
            a.kind = EV_ERR;
            a.data = 32'd0;
            score(a);
         end
      end
      busy_q <= busy;
   end

   function automatic void push(ev_kind_t k, logic [31:0] d,
                                logic [31:0] lay, logic [31:0] neu,
                                logic [15:0] fr, logic bz);
      ev_t e;
      e.kind   = k;
      e.data   = d;
      e.layer  = lay;
      e.neuron = neu;
      e.frames = fr;
      e.bz     = bz;
      e.cyc    = cyc + 1;
      exp_q.push_back(e);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_data  = $urandom;
   endtask

   task automatic present(logic [31:0] d, int gap);
      while ($urandom_range(0, 99) < gap) begin
         s_valid = 1'b0;
         s_data  = $urandom;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b1;
      s_data  = d;
   endtask

   task automatic idle(int n);
      repeat (n) step();
   endtask

   task automatic send_frame(logic [31:0] hdr, logic [31:0] n, int gap,
                             logic [31:0] ws[$], logic [31:0] bias);
      logic [31:0] lay;
      logic [31:0] neu;
      logic [31:0] d;
      lay = hdr >> 16;
      neu = hdr & 32'h0000_FFFF;
      present(hdr, gap);
      push(EV_HDR, 32'd0, lay, neu, m_frames, 1'b1);
      step();
      present(n, gap);
      if (n == 0 || n > MAXW) begin
         push(EV_ERR, 32'd0, lay, neu, m_frames, 1'b0);
         step();
         return;
      end
      step();
      for (int i = 0; i < int'(n); i++) begin
         d = (i < ws.size()) ? ws[i] : $urandom;
         present(d, gap);
         if (i == int'(n) - 1 && !BIAS_EN) begin
            m_frames++;
            push(EV_W, d, lay, neu, m_frames, 1'b0);
            push(EV_DONE, 32'd0, lay, neu, m_frames, 1'b0);
         end else begin
            push(EV_W, d, lay, neu, m_frames, 1'b1);
         end
         step();
      end
      if (BIAS_EN) begin
         present(bias, gap);
         m_frames++;
         push(EV_B, bias, lay, neu, m_frames, 1'b0);
         push(EV_DONE, 32'd0, lay, neu, m_frames, 1'b0);
         step();
      end
   endtask

   task automatic check_idle(string tag, logic rdy);
      @(negedge clk);
      chk({tag, "_wv"}, {31'd0, weightValid}, 32'd0);
      chk({tag, "_bv"}, {31'd0, biasValid}, 32'd0);
      chk({tag, "_done"}, {31'd0, frame_done}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_wval"}, weightValue, 32'd0);
      chk({tag, "_bval"}, biasValue, 32'd0);
      chk({tag, "_frames"}, {16'd0, frames_loaded}, 32'd0);
      chk({tag, "_layer"}, config_layer_num, 32'hFFFF_FFFF);
      chk({tag, "_neuron"}, config_neuron_num, 32'hFFFF_FFFF);
      chk({tag, "_ready"}, {31'd0, s_ready}, {31'd0, rdy});
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] none[$];
      logic [31:0] abc[$];
      logic [31:0] n;
      logic [31:0] hdr;
      abc = '{32'hA, 32'hB, 32'hC};

      repeat (3) @(posedge clk);
      #1;
      check_idle("reset", 1'b0);
      rst = 1'b0;
      check_idle("post_reset", 1'b1);

      send_frame(32'h0001_001C, 3, 0, abc, 32'h78B);
      idle(2);
      chk("frames_after_first", {16'd0, frames_loaded}, {16'd0, m_frames});

      send_frame(32'h0001_001C, 3, 45, abc, 32'h78B);
      send_frame(32'h0003_0007, 0, 0, none, 32'd0);
      send_frame(32'h0003_0008, 785, 30, none, 32'd0);
      send_frame(32'h0004_0009, 5, 30, none, $urandom);
      send_frame(32'h0005_000A, 2, 0, none, $urandom);
      idle(2);
      chk("queue_drained_1", exp_q.size(), 32'd0);

      present(32'h0002_0005, 0);
      push(EV_HDR, 32'd0, 32'd2, 32'd5, m_frames, 1'b1);
      step();
      present(32'd3, 0);
      step();
      for (int i = 0; i < 2; i++) begin
         present(32'h100 + i, 0);
         push(EV_W, 32'h100 + i, 32'd2, 32'd5, m_frames, 1'b1);
         step();
      end
      idle(2);
      chk("queue_drained_pre_rst", exp_q.size(), 32'd0);
      rst = 1'b1;
      s_valid = 1'b1;
      s_data = 32'h102;
      @(posedge clk);
      #1;
      check_idle("mid_rst", 1'b0);
      rst = 1'b0;
      s_valid = 1'b0;
      m_frames = 16'd0;
      idle(3);
      check_idle("after_mid_rst", 1'b1);
      send_frame(32'h0002_0005, 3, 20, none, $urandom);
      idle(2);
      chk("frames_after_rst", {16'd0, frames_loaded}, 32'd1);

      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      m_frames = 16'd0;
      idle(2);
      wcount = 0;
      send_frame(32'h0001_0000, MAXW, 0, none, $urandom);
      send_frame(32'h0001_0001, MAXW, 0, none, $urandom);
      idle(2);
      chk("wcount_two_full", wcount, 2 * MAXW);
      chk("frames_two_full", {16'd0, frames_loaded}, 32'd2);

      for (int k = 0; k < 12; k++) begin
         hdr = $urandom;
         if ($urandom_range(0, 7) == 0)
            n = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom_range(785, 5000);
         else
            n = $urandom_range(1, 12);
         send_frame(hdr, n, $urandom_range(0, 50), none, $urandom);
      end

      for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
      idle(1);
      chk("queue_drained_end", exp_q.size(), 32'd0);
      chk("frames_end", {16'd0, frames_loaded}, {16'd0, m_frames});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
